// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// int_defs : FSM states, CP0 register numbers and Cause-word helper for int_ctrl.
// Revision : 1.0
// -----------------------------------------------------------------------------
package int_defs;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE_EPC   = 3'd1,
    SAVE_CAUSE = 3'd2,
    JUMP       = 3'd3,
    SERVICE    = 3'd4,
    RETURN     = 3'd5
  } int_state_t;

  localparam logic [4:0] c_cp0_status = 5'd12;
  localparam logic [4:0] c_cp0_cause  = 5'd13;
  localparam logic [4:0] c_cp0_epc    = 5'd14;
  localparam logic [4:0] c_exc_int    = 5'd0;
  localparam int         c_ip_base    = 8;
  // Source ids are 3 bits wide so up to eight lines fit Cause.IP.
  localparam int         c_id_w       = 3;

  function automatic logic [31:0] cause_word(input logic [7:0] ip);
    return (32'(ip) << c_ip_base) | (32'(c_exc_int) << 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/int_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// int_ctrl_if : request, CP0 write-port and pipeline-control bundle of int_ctrl.
// Revision    : 1.0
// -----------------------------------------------------------------------------
interface int_ctrl_if #(
  parameter int IRQ_NUM = 4
);
  logic [IRQ_NUM-1:0] irq;
  logic               ie_in;
  logic               pipe_ok;
  logic [31:0]        pc_now;
  logic               eret;
  logic               cp0_we;
  logic [4:0]         cp0_waddr;
  logic [31:0]        cp0_wdata;
  logic               ie_zero;
  logic               ie_one;
  logic               int_stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [IRQ_NUM-1:0] irq_ack;
  logic               busy;
  logic [IRQ_NUM-1:0] pending;

  modport master (
    input  irq, ie_in, pipe_ok, pc_now, eret,
    output cp0_we, cp0_waddr, cp0_wdata, ie_zero, ie_one, int_stall,
           redirect, redirect_pc, irq_ack, busy, pending
  );

  modport slave (
    output irq, ie_in, pipe_ok, pc_now, eret,
    input  cp0_we, cp0_waddr, cp0_wdata, ie_zero, ie_one, int_stall,
           redirect, redirect_pc, irq_ack, busy, pending
  );
endinterface
`default_nettype wire

// File: rtl/int_ctrl_prio_enc.sv
`default_nettype none
// -----------------------------------------------------------------------------
// int_prio_enc : fixed-priority encoder, lowest set index wins.
// Revision     : 1.0
// -----------------------------------------------------------------------------
module int_prio_enc
  import int_defs::*;
#(
  parameter int IRQ_NUM = 4
) (
  input  logic [IRQ_NUM-1:0] pending,
  output logic               valid,
  output logic [c_id_w-1:0]  id
);

  // Scanning downward lets the lowest set index overwrite the rest.
  always_comb begin
    id = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pending[i]) id = c_id_w'(i);
    end
  end

  assign valid = |pending;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// int_ctrl : external interrupt controller driving the CP0 write port; INT_EDGE_EN selects edge-latched pending.
// Revision : 1.0
// -----------------------------------------------------------------------------
module int_ctrl
  import int_defs::*;
#(
  parameter int          IRQ_NUM    = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_3000,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0100
) (
  input  logic      clk,
  input  logic      clr_n,
  int_ctrl_if.master bus
);

  int_state_t         r_state;
  logic [c_id_w-1:0]  r_id;
  logic [c_id_w-1:0]  w_win_id;
  logic               w_win_valid;
  logic [IRQ_NUM-1:0] r_sync1;
  logic [IRQ_NUM-1:0] r_sync2;
  logic [IRQ_NUM-1:0] w_pending;
  logic [IRQ_NUM-1:0] r_snap;
  logic [IRQ_NUM-1:0] r_irq_ack;
  logic               r_cp0_we;
  logic [4:0]         r_cp0_waddr;
  logic [31:0]        r_cp0_wdata;
  logic               r_ie_zero;
  logic               r_ie_one;
  logic               r_int_stall;
  logic               r_redirect;
  logic [31:0]        r_redirect_pc;
  logic               r_busy;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.irq;
      r_sync2 <= r_sync1;
    end
  end

`ifdef INT_EDGE_EN
  logic [IRQ_NUM-1:0] r_sync3;
  logic [IRQ_NUM-1:0] r_pend;
  logic [IRQ_NUM-1:0] w_rise;
  logic [IRQ_NUM-1:0] w_clr;

  assign w_rise = r_sync2 & ~r_sync3;
  assign w_clr  = (r_state == JUMP) ? (IRQ_NUM'(1) << r_id) : '0;

  // A fresh edge in the clearing cycle is kept, so set wins over clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_sync3 <= '0;
      r_pend  <= '0;
    end else begin
      r_sync3 <= r_sync2;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
    end
  end

  assign w_pending = r_pend | w_rise;
`else
  assign w_pending = r_sync2;
`endif

  int_prio_enc #(
    .IRQ_NUM (IRQ_NUM)
  ) u_prio (
    .pending (w_pending),
    .valid   (w_win_valid),
    .id      (w_win_id)
  );

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state       <= IDLE;
      r_id          <= '0;
      r_snap        <= '0;
      r_cp0_we      <= 1'b0;
      r_cp0_waddr   <= '0;
      r_cp0_wdata   <= '0;
      r_ie_zero     <= 1'b0;
      r_ie_one      <= 1'b0;
      r_int_stall   <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_irq_ack     <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_cp0_we      <= 1'b0;
      r_cp0_waddr   <= '0;
      r_cp0_wdata   <= '0;
      r_ie_zero     <= 1'b0;
      r_ie_one      <= 1'b0;
      r_int_stall   <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_irq_ack     <= '0;
      r_busy        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.ie_in && w_win_valid && bus.pipe_ok) begin
            r_state     <= SAVE_EPC;
            r_id        <= w_win_id;
            r_snap      <= w_pending;
            r_int_stall <= 1'b1;
            r_cp0_we    <= 1'b1;
            r_cp0_waddr <= c_cp0_epc;
            r_cp0_wdata <= bus.pc_now;
            r_ie_zero   <= 1'b1;
          end
        end
        SAVE_EPC: begin
          r_state     <= SAVE_CAUSE;
          r_int_stall <= 1'b1;
          r_cp0_we    <= 1'b1;
          r_cp0_waddr <= c_cp0_cause;
          r_cp0_wdata <= cause_word(8'(r_snap));
        end
        SAVE_CAUSE: begin
          r_state       <= JUMP;
          r_int_stall   <= 1'b1;
          r_redirect    <= 1'b1;
          r_redirect_pc <= VEC_BASE + VEC_STRIDE * 32'(r_id);
          r_irq_ack     <= IRQ_NUM'(1) << r_id;
        end
        JUMP: begin
          r_state <= SERVICE;
          r_busy  <= 1'b1;
        end
        SERVICE: begin
          if (bus.eret) begin
            r_state  <= RETURN;
            r_ie_one <= 1'b1;
          end else begin
            r_busy <= 1'b1;
          end
        end
        RETURN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cp0_we      = r_cp0_we;
  assign bus.cp0_waddr   = r_cp0_waddr;
  assign bus.cp0_wdata   = r_cp0_wdata;
  assign bus.ie_zero     = r_ie_zero;
  assign bus.ie_one      = r_ie_one;
  assign bus.int_stall   = r_int_stall;
  assign bus.redirect    = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.irq_ack     = r_irq_ack;
  assign bus.busy        = r_busy;
  assign bus.pending     = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_int_ctrl : vector table, directed corner sequences and random run against a reference model.
// Revision    : 1.0
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  int_ctrl_if #(.IRQ_NUM(N)) bus ();

  int_ctrl #(
    .IRQ_NUM    (N),
    .VEC_BASE   (32'h0000_3000),
    .VEC_STRIDE (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ie_zero;
    logic        ie_one;
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [3:0]  ack;
    logic        busy;
  } outs_t;

  typedef struct packed {
    logic [3:0]  irq;
    logic        ie;
    logic        ok;
    logic        eret;
    logic [31:0] pc;
    outs_t       exp;
    logic [3:0]  pend;
  } vec_t;

`ifdef INT_EDGE_EN
  localparam bit TAB_PEND = 1'b0;
`else
  localparam bit TAB_PEND = 1'b1;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: sync history, visible pending, queued entry outputs.
  logic [3:0] h1, h2, h3, vis;
  outs_t      mq[$];
  bit         svc, blk;
  logic [2:0] mid;

  function automatic outs_t rec_epc(input logic [31:0] pc);
    outs_t o = '0;
    o.we = 1'b1; o.waddr = 5'd14; o.wdata = pc; o.ie_zero = 1'b1; o.stall = 1'b1;
    return o;
  endfunction

  function automatic outs_t rec_cause(input logic [31:0] w);
    outs_t o = '0;
    o.we = 1'b1; o.waddr = 5'd13; o.wdata = w; o.stall = 1'b1;
    return o;
  endfunction

  function automatic outs_t rec_jump(input logic [31:0] pc, input logic [3:0] ack);
    outs_t o = '0;
    o.stall = 1'b1; o.redirect = 1'b1; o.rpc = pc; o.ack = ack;
    return o;
  endfunction

  function automatic outs_t rec_busy();
    outs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t rec_ie1();
    outs_t o = '0;
    o.ie_one = 1'b1;
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o.we = bus.cp0_we; o.waddr = bus.cp0_waddr; o.wdata = bus.cp0_wdata;
    o.ie_zero = bus.ie_zero; o.ie_one = bus.ie_one; o.stall = bus.int_stall;
    o.redirect = bus.redirect; o.rpc = bus.redirect_pc; o.ack = bus.irq_ack;
    o.busy = bus.busy;
    return o;
  endfunction

  function automatic vec_t mkv(input logic [3:0] irq, input logic ie, input logic ok,
                               input logic eret, input logic [31:0] pc,
                               input outs_t exp, input logic [3:0] pend);
    vec_t v;
    v.irq = irq; v.ie = ie; v.ok = ok; v.eret = eret; v.pc = pc; v.exp = exp; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input outs_t exp, input logic [3:0] exp_pend,
                       input bit use_pend);
    outs_t act;
    act = dut_outs();
    checks++;
    if (act !== exp || (use_pend && bus.pending !== exp_pend)) begin
      errors++;
      $display("FAIL %s: got outs=%h pending=%b, want outs=%h pending=%b",
               name, act, bus.pending, exp, exp_pend);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] irq, input logic ie, input logic ok,
                       input logic eret, input logic [31:0] pc);
    bus.irq = irq; bus.ie_in = ie; bus.pipe_ok = ok; bus.eret = eret; bus.pc_now = pc;
  endtask

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0; vis = '0;
    mq.delete();
    svc = 1'b0; blk = 1'b0; mid = '0;
  endtask

  // Predicts outputs and pending seen after the next rising edge from the current inputs.
  task automatic model_edge(output outs_t o, output logic [3:0] p);
    logic [3:0] pb;
    int         id;
`ifdef INT_EDGE_EN
    logic [3:0] clr;
    logic [3:0] rise_cur;
    logic [3:0] rise_new;
    clr = '0;
`endif
    o  = '0;
    pb = vis;
    if (blk) begin
      blk = 1'b0;
    end else if (mq.size() > 0) begin
      o = mq.pop_front();
      if (mq.size() == 0) begin
        svc = 1'b1;
`ifdef INT_EDGE_EN
        clr = 4'b0001 << mid;
`endif
      end
    end else if (svc) begin
      if (bus.eret) begin
        o = rec_ie1(); svc = 1'b0; blk = 1'b1;
      end else begin
        o = rec_busy();
      end
    end else if (bus.ie_in && bus.pipe_ok && pb != 4'b0000) begin
      id = 0;
      while (pb[id] == 1'b0) id++;
      mid = id[2:0];
      o = rec_epc(bus.pc_now);
      mq.push_back(rec_cause(32'(pb) << 8));
      mq.push_back(rec_jump(32'h0000_3000 + 32'(id) * 32'h0000_0100, 4'b0001 << id));
      mq.push_back(rec_busy());
    end
`ifdef INT_EDGE_EN
    rise_cur = h2 & ~h3;
`endif
    h3 = h2; h2 = h1; h1 = bus.irq;
`ifdef INT_EDGE_EN
    rise_new = h2 & ~h3;
    vis = (vis & ~clr) | (clr & rise_cur) | rise_new;
`else
    vis = h2;
`endif
    p = vis;
  endtask

  task automatic step(input string name);
    outs_t      e;
    logic [3:0] p;
    model_edge(e, p);
    @(posedge clk);
    #1;
    check(name, e, p, 1'b1);
  endtask

  vec_t tab[23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 32'h0);

    tab[0]  = mkv(4'b0100, 1, 1, 0, 32'h40, '0,                            4'b0000);
    tab[1]  = mkv(4'b0100, 1, 1, 0, 32'h40, '0,                            4'b0100);
    tab[2]  = mkv(4'b0100, 1, 1, 0, 32'h40, rec_epc(32'h40),               4'b0100);
    tab[3]  = mkv(4'b0100, 1, 1, 0, 32'h40, rec_cause(32'h0000_0400),      4'b0100);
    tab[4]  = mkv(4'b0100, 1, 1, 0, 32'h40, rec_jump(32'h3200, 4'b0100),   4'b0100);
    tab[5]  = mkv(4'b0000, 1, 1, 0, 32'h40, rec_busy(),                    4'b0100);
    tab[6]  = mkv(4'b0000, 1, 1, 1, 32'h40, rec_ie1(),                     4'b0000);
    tab[7]  = mkv(4'b0000, 1, 1, 0, 32'h40, '0,                            4'b0000);
    tab[8]  = mkv(4'b0000, 1, 1, 1, 32'h40, '0,                            4'b0000);
    tab[9]  = mkv(4'b1010, 1, 1, 0, 32'h80, '0,                            4'b0000);
    tab[10] = mkv(4'b1010, 1, 1, 0, 32'h80, '0,                            4'b1010);
    tab[11] = mkv(4'b1010, 1, 1, 0, 32'h80, rec_epc(32'h80),               4'b1010);
    tab[12] = mkv(4'b1010, 1, 1, 0, 32'h80, rec_cause(32'h0000_0A00),      4'b1010);
    tab[13] = mkv(4'b1010, 1, 1, 0, 32'h80, rec_jump(32'h3100, 4'b0010),   4'b1010);
    tab[14] = mkv(4'b1000, 1, 1, 0, 32'h80, rec_busy(),                    4'b1010);
    tab[15] = mkv(4'b1000, 1, 1, 1, 32'h80, rec_ie1(),                     4'b1000);
    tab[16] = mkv(4'b1000, 1, 1, 0, 32'h80, '0,                            4'b1000);
    tab[17] = mkv(4'b1000, 1, 1, 0, 32'h80, rec_epc(32'h80),               4'b1000);
    tab[18] = mkv(4'b1000, 1, 1, 0, 32'h80, rec_cause(32'h0000_0800),      4'b1000);
    tab[19] = mkv(4'b1000, 1, 1, 0, 32'h80, rec_jump(32'h3300, 4'b1000),   4'b1000);
    tab[20] = mkv(4'b0000, 1, 1, 0, 32'h80, rec_busy(),                    4'b1000);
    tab[21] = mkv(4'b0000, 1, 1, 1, 32'h80, rec_ie1(),                     4'b0000);
    tab[22] = mkv(4'b0000, 1, 1, 0, 32'h80, '0,                            4'b0000);

    #12;
    check("reset_state", '0, 4'b0000, 1'b1);
    clr_n = 1'b1;

    for (int k = 0; k < 23; k++) begin
      drive(tab[k].irq, tab[k].ie, tab[k].ok, tab[k].eret, tab[k].pc);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", k), tab[k].exp, tab[k].pend, TAB_PEND);
    end

    // Asynchronous reset in the middle of an entry with every line requesting.
    model_reset();
    drive(4'b1111, 1, 1, 0, 32'h100);
    for (int k = 0; k < 4; k++) step($sformatf("pre_rst%0d", k));
    #3;
    clr_n = 1'b0;
    #1;
    check("async_reset", '0, 4'b0000, 1'b1);
    @(posedge clk);
    #1;
    check("reset_hold", '0, 4'b0000, 1'b1);
    #3;
    clr_n = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) step($sformatf("post_rst%0d", k));
    bus.eret = 1'b1;
    step("post_rst_eret");
    bus.eret = 1'b0;
    step("post_rst_ret");

    // Gating: entry must wait for both ie_in and pipe_ok.
    drive(4'b0001, 0, 1, 0, 32'h200);
    for (int k = 0; k < 10; k++) step($sformatf("gate_ie%0d", k));
    drive(4'b0001, 1, 0, 0, 32'h200);
    for (int k = 0; k < 10; k++) step($sformatf("gate_ok%0d", k));
    bus.pipe_ok = 1'b1;
    step("gate_open");
    check_val("gate_open_waddr", 32'(bus.cp0_waddr), 32'd14);
    bus.ie_in = 1'b0;
    for (int k = 0; k < 3; k++) step($sformatf("gate_run%0d", k));
    check_val("gate_busy", 32'(bus.busy), 32'd1);
    bus.eret = 1'b1;
    step("gate_eret");
    bus.eret = 1'b0;
    step("gate_ret");

`ifdef INT_EDGE_EN
    drive(4'b0000, 0, 1, 0, 32'h300);
    for (int k = 0; k < 2; k++) step("edge_idle");
    bus.irq = 4'b0010;
    for (int k = 0; k < 3; k++) step("edge_pulse");
    bus.irq = 4'b0000;
    for (int k = 0; k < 5; k++) step("edge_hold");
    check_val("edge_latched", 32'(bus.pending[1]), 32'd1);
    bus.ie_in = 1'b1;
    for (int k = 0; k < 4; k++) step("edge_entry");
    check_val("edge_cleared", 32'(bus.pending[1]), 32'd0);
    bus.ie_in = 1'b0;
    bus.eret  = 1'b1;
    step("edge_eret");
    bus.eret  = 1'b0;
    step("edge_ret");
`endif

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] t;
      t = 4'($urandom) & 4'($urandom) & 4'($urandom);
      bus.irq     = bus.irq ^ t;
      bus.ie_in   = ($urandom_range(0, 7) != 0);
      bus.pipe_ok = ($urandom_range(0, 3) != 0);
      bus.eret    = ($urandom_range(0, 5) == 0);
      bus.pc_now  = $urandom & 32'hFFFF_FFFC;
      step($sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- External interrupt controller sitting directly upstream of the CP0 register file.
- Synchronises device requests, latches them as pending and selects one by fixed priority.
- Sequences interrupt entry: writes EPC and Cause through the CP0 write port, drops Status.IE and redirects the PC to a per-source vector.
- On ERET it re-enables IE through the CP0 IE-set strobe.

Parameters:
- IRQ_NUM, 4, number of request lines; legal range 1..8, since they map to Cause.IP[15:8].
- VEC_BASE, 32'h0000_3000, handler address for source 0.
- VEC_STRIDE, 32'h0000_0100, address spacing between consecutive handlers.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- irq  in  IRQ_NUM  device requests, asynchronous to clk.
- ie_in  in  1  Status.IE from CP0.
- pipe_ok  in  1  pipeline is at an instruction boundary and may be interrupted.
- pc_now  in  32  resume PC to be saved as EPC.
- eret  in  1  one-cycle pulse when ERET commits.
- cp0_we  out  1  CP0 write enable.
- cp0_waddr  out  5  CP0 register number.
- cp0_wdata  out  32  CP0 write data.
- ie_zero  out  1  CP0 IE clear strobe.
- ie_one  out  1  CP0 IE set strobe.
- int_stall  out  1  freezes the pipeline during entry.
- redirect  out  1  PC-mux select for the handler address.
- redirect_pc  out  32  handler address.
- irq_ack  out  IRQ_NUM  one-hot acknowledge of the serviced source.
- busy  out  1  a handler is in service.
- pending  out  IRQ_NUM  current pending vector.

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE; synchroniser flops, pending, captured id and EPC snapshot all cleared; every output 0.
- Synchronisation: two flops per irq line. An irq edge is visible in pending 2 cycles later.
- Default pending mode (level): pending = synchronised irq. The device holds irq until it sees irq_ack or is serviced by software.
- Priority: the lowest set index wins; combinational over pending.
- FSM, all outputs decoded from state (Moore):
  - IDLE: if ie_in && |pending && pipe_ok, capture winner id and pc_now, then go to SAVE_EPC. Otherwise stay.
  - SAVE_EPC: int_stall=1; cp0_we=1; cp0_waddr=14; cp0_wdata=captured PC; ie_zero=1. Next state SAVE_CAUSE.
  - SAVE_CAUSE: int_stall=1; cp0_we=1; cp0_waddr=13; cp0_wdata bits [8+IRQ_NUM-1:8] = pending snapshot taken at the IDLE exit; ExcCode [6:2]=0; all other bits 0. Next state JUMP.
  - JUMP: int_stall=1; redirect=1; redirect_pc = VEC_BASE + id*VEC_STRIDE, 32-bit wrap; irq_ack[id]=1. Next state SERVICE.
  - SERVICE: busy=1, int_stall=0. On eret go to RETURN; otherwise stay.
  - RETURN: ie_one=1 for exactly one cycle, then IDLE. No entry is taken in RETURN.
- Entry latency: 3 cycles from the IDLE decision to redirect.
- The winner is frozen at the IDLE exit. A higher-priority request arriving later waits for IDLE.
- ie_in or pipe_ok dropping after the IDLE exit has no effect on an entry already under way.
- Requests arriving during SAVE_EPC..RETURN stay pending.
- eret is ignored in every state except SERVICE.
- pending dropping to 0 in IDLE: no entry.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. CP0 state already written is left as is.

Optional Feature:
- Macro INT_EDGE_EN.
- Defined: pending[i] is set on a rising edge of synchronised irq[i] and is cleared in the JUMP cycle for id. If a new edge arrives in that same cycle, set wins. irq level is ignored after the edge.
- Undefined: level mode as above. No edge-detect flops are instantiated.

Decomposition:
- Shared package int_defs holds:
  - FSM state encodings: IDLE, SAVE_EPC, SAVE_CAUSE, JUMP, SERVICE, RETURN.
  - CP0 register numbers: STATUS=12, CAUSE=13, EPC=14.
  - EXC_INT=0.
  - Cause.IP base bit = 8.
- One sub-module: int_prio_enc, parameterised by IRQ_NUM, takes pending and returns valid and the winner id.

Test Plan:
- Reset: clr_n=0 mid-run with irq=4'b1111 -> all outputs 0 asynchronously; pending=0 until 2 cycles after release.
- Single request: irq[2]=1, ie_in=1, pipe_ok=1, pc_now=0x40. Required sequence:
  - SAVE_EPC: cp0_we, waddr 14, wdata 0x40, ie_zero.
  - SAVE_CAUSE: waddr 13, wdata 0x0000_0400.
  - JUMP: redirect_pc 0x3200, irq_ack=4'b0100.
  - SERVICE: busy=1.
- Simultaneous irq[1] and irq[3] -> id 1, redirect_pc 0x3100, Cause wdata 0x0000_0A00; irq[3] is taken after ERET.
- Gating: ie_in=0 or pipe_ok=0 with irq[0] high -> stays IDLE for 10 cycles; raising both -> SAVE_EPC the next cycle.
- ERET: eret pulse in SERVICE -> ie_one=1 for one cycle, then IDLE. An eret pulse while in IDLE -> no output.
- INT_EDGE_EN: a 3-cycle pulse on irq[1] -> pending[1] stays set after irq falls and clears in the JUMP cycle. Reset asserted during SAVE_CAUSE -> IDLE with outputs 0.
